// File: rtl/tb_uart_if.sv
// tb_uart_if: serial line and receive-side outputs of the tb_uart monitor.
// Signals: ser_rx (idle-high line from the SoC), rx_data, rx_valid, frame_err, line_done, busy, char_count.
// master drives the line and observes results; slave is the receiver.
interface tb_uart_if;
  logic        ser_rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        line_done;
  logic        busy;
  logic [15:0] char_count;
  modport master (output ser_rx, input rx_data, rx_valid, frame_err, line_done, busy, char_count);
  modport slave (input ser_rx, output rx_data, rx_valid, frame_err, line_done, busy, char_count);
endinterface

// File: rtl/tb_uart.sv
// tb_uart: 8N1 UART receiver/monitor with framing-error detection, character count and end-of-line pulse.
// Ports: core_clk (rising-edge clock), core_rst (async active-high reset),
// bus (tb_uart_if.slave: ser_rx in; rx_data, rx_valid, frame_err, line_done, busy, char_count out).
module tb_uart #(
  parameter int         CLKS_PER_BIT = 4167,
  parameter logic [7:0] EOL_CHAR     = 8'h0A
) (
  input logic      core_clk,
  input logic      core_rst,
  tb_uart_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t        r_state, w_next;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift, r_rx_data;
  logic          r_rx_valid, r_frame_err, r_line_done;
  logic [15:0]   r_char_count;
  logic          w_rx, w_half, w_full, w_sample, w_good, w_ferr, w_clr;
  assign w_rx   = r_sync[1];
  assign w_half = r_cnt == HALF;
  assign w_full = r_cnt == FULL;
  always_ff @(posedge core_clk or posedge core_rst)
    if (core_rst) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], bus.ser_rx};
  always_ff @(posedge core_clk or posedge core_rst)
    if (core_rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_rx ? IDLE : START;
      START:     w_next = !w_half ? START : w_rx ? IDLE : DATA;
      DATA:      w_next = (w_full && r_idx == 3'd7) ? STOP : DATA;
      STOP:      w_next = !w_full ? STOP : w_rx ? IDLE : WAIT_HIGH;
      WAIT_HIGH: w_next = w_rx ? IDLE : WAIT_HIGH;
      default:   w_next = IDLE;
    endcase
  end
  // The counter restarts on every state change and every full bit period,
  // so START measures a half bit and DATA/STOP land on bit centres.
  always_comb begin
    w_sample = r_state == DATA && w_full;
    w_good   = r_state == STOP && w_full && w_rx;
    w_ferr   = r_state == STOP && w_full && !w_rx;
    w_clr    = r_state == IDLE || r_state == WAIT_HIGH || w_next != r_state || w_full;
  end
  always_ff @(posedge core_clk or posedge core_rst)
    if (core_rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_line_done  <= 1'b0;
      r_char_count <= '0;
    end else begin
      r_cnt        <= w_clr ? '0 : r_cnt + CW'(1);
      r_idx        <= r_state != DATA ? '0 : r_idx + 3'(w_sample);
      if (w_sample) r_shift[r_idx] <= w_rx;
      r_rx_data    <= w_good ? r_shift : r_rx_data;
      r_rx_valid   <= w_good;
      r_frame_err  <= w_ferr;
      r_line_done  <= w_good && r_shift == EOL_CHAR;
      r_char_count <= w_good ? r_char_count + 16'd1 : r_char_count;
    end
  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.line_done  = r_line_done;
  assign bus.busy       = r_state != IDLE;
  assign bus.char_count = r_char_count;
endmodule

// File: tb/tb_tb_uart.sv
// tb_tb_uart: directed and randomized frames checked against an event-queue reference model of tb_uart.
module tb_tb_uart;
  localparam int CPB = 16;
  localparam logic [7:0] EOL = 8'h0A;
  typedef struct {bit err; logic [7:0] data;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  tb_uart_if bus();
  tb_uart #(.CLKS_PER_BIT(CPB), .EOL_CHAR(EOL)) dut (.core_clk(clk), .core_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  ev_t exp_q[$];
  int n_chk = 0, n_pass = 0, cyc = 0, t_valid = 0, n_valid = 0, n_ferr = 0, n_ld = 0;
  logic [15:0] m_count;
  logic [7:0]  m_last;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin : mon
    ev_t e;
    if (rst) begin
      m_count = 0;
      m_last  = 0;
    end else if (bus.rx_valid || bus.frame_err || bus.line_done) begin
      if (bus.rx_valid) begin n_valid++; t_valid = cyc; end
      if (bus.frame_err) n_ferr++;
      if (bus.line_done) n_ld++;
      if (exp_q.size() == 0) chk("spurious", {bus.rx_valid, bus.frame_err, bus.line_done}, 0);
      else begin
        e = exp_q.pop_front();
        chk("pulse_kind", {bus.rx_valid, bus.frame_err}, e.err ? 2'b01 : 2'b10);
        if (!e.err) begin m_count = m_count + 16'd1; m_last = e.data; end
        chk("rx_data", bus.rx_data, m_last);
        chk("line_done", bus.line_done, !e.err && e.data == EOL);
        chk("char_count", bus.char_count, m_count);
      end
    end
  end
  task automatic bit_(input logic v, input int n = CPB);
    bus.ser_rx = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    exp_q.push_back('{err: !stop, data: b});
    bit_(1'b0);
    for (int i = 0; i < 8; i++) bit_(b[i]);
    bit_(stop);
  endtask
  task automatic do_reset();
    chk("pending_before_reset", exp_q.size(), 0);
    exp_q.delete();
    bus.ser_rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [27:0] acc;
    logic [7:0]  b;
    logic        stop;
    int t0, v0, f0, l0;
    logic [15:0] c0;
    bus.ser_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_line_done", bus.line_done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_char_count", bus.char_count, 0);
    rst = 1'b0;
    acc = '0;
    repeat (1000) begin
      @(negedge clk);
      acc |= {bus.rx_valid, bus.frame_err, bus.line_done, bus.busy, bus.rx_data, bus.char_count};
    end
    chk("idle_quiet", acc, 0);
    v0 = n_valid;
    t0 = cyc;
    send(8'h55, 1'b1);
    chk("latency_154pm1", (t_valid - t0 >= 153 && t_valid - t0 <= 155) ? 154 : t_valid - t0, 154);
    chk("x55_data", bus.rx_data, 8'h55);
    chk("x55_count", bus.char_count, 1);
    chk("x55_pulses", n_valid - v0, 1);
    do_reset();
    v0 = n_valid;
    l0 = n_ld;
    send(8'h4F, 1'b1);
    send(8'h4B, 1'b1);
    send(8'h0A, 1'b1);
    bit_(1'b1, 4);
    chk("ok_pulses", n_valid - v0, 3);
    chk("ok_line_done", n_ld - l0, 1);
    chk("ok_count", bus.char_count, 3);
    chk("ok_data", bus.rx_data, 8'h0A);
    v0 = n_valid;
    f0 = n_ferr;
    send(8'hA5, 1'b0);
    bit_(1'b0, 40);
    bit_(1'b1, 20);
    chk("ferr_pulses", n_ferr - f0, 1);
    chk("ferr_no_valid", n_valid - v0, 0);
    chk("ferr_data_held", bus.rx_data, 8'h0A);
    chk("ferr_count_held", bus.char_count, 3);
    c0 = bus.char_count;
    v0 = n_valid;
    f0 = n_ferr;
    bit_(1'b0, 4);
    chk("glitch_busy", bus.busy, 1);
    bit_(1'b1, 20);
    chk("glitch_idle", bus.busy, 0);
    chk("glitch_quiet", (n_valid - v0) + (n_ferr - f0), 0);
    chk("glitch_count", bus.char_count, c0);
    b = 8'h3C;
    bit_(1'b0);
    for (int i = 0; i < 3; i++) bit_(b[i]);
    bit_(b[3], 8);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    bus.ser_rx = 1'b1;
    rst = 1'b0;
    bit_(1'b1, 40);
    chk("midrst_data", bus.rx_data, 0);
    chk("midrst_count", bus.char_count, 0);
    send(8'h81, 1'b1);
    bit_(1'b1, 4);
    chk("x81_data", bus.rx_data, 8'h81);
    chk("x81_count", bus.char_count, 1);
    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) b = EOL;
      stop = $urandom_range(0, 7) != 0;
      send(b, stop);
      if (!stop) bit_(1'b0, $urandom_range(0, 30));
      bit_(1'b1, stop ? $urandom_range(0, 3) : $urandom_range(4, 10));
    end
    bit_(1'b1, 200);
    chk("pending_end", exp_q.size(), 0);
    chk("final_count", bus.char_count, m_count);
    chk("final_busy", bus.busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
